// File: rtl/comb_stack_if.sv
// Operand-stack bus between the C(n,m) controller (master) and comb_stack (slave).
// push/pop are single-cycle strobes with no back-pressure; is_empty/is_full/count are registered status.
interface comb_stack_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 7
);
    logic             clr;
    logic             push;
    logic             pop;
    logic [1:0]       sel_stack;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] dout;
    logic             is_empty;
    logic             is_full;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             udf;
    logic [CNT_W-1:0] max_depth;

    modport master (
        output clr, push, pop, sel_stack, d0, d1, d2,
        input  dout, is_empty, is_full, count, ovf, udf, max_depth
    );

    modport slave (
        input  clr, push, pop, sel_stack, d0, d1, d2,
        output dout, is_empty, is_full, count, ovf, udf, max_depth
    );
endinterface

// File: rtl/comb_stack.sv
// LIFO operand stack for the C(n,m) controller; popped word is returned on a registered dout.
// Optional high-water mark on max_depth is enabled by defining COMB_STACK_WATERMARK_EN.
module comb_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic         clk,
    input  logic         rst,
    comb_stack_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             empty, full;
    logic [WIDTH-1:0] push_word;
    logic [AW-1:0]    top_idx;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    // count is in 1..DEPTH whenever top_idx is used, so the low-bit wrap at DEPTH is intended.
    assign top_idx = count_q[AW-1:0] - AW'(1);

    always_comb begin
        push_word = '0;
        case (bus.sel_stack)
            2'd0:    push_word = bus.d0;
            2'd1:    push_word = bus.d1;
            2'd2:    push_word = bus.d2;
            default: push_word = '0;
        endcase
    end

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_en   = 1'b0;
        wr_addr = count_q[AW-1:0];
        if (bus.clr) begin
            count_d = '0;
            dout_d  = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (bus.push && bus.pop) begin
            if (empty) begin
                // Push lands in slot 0; the pop has nothing to return.
                wr_en   = 1'b1;
                wr_addr = '0;
                count_d = CNT_W'(1);
                udf_d   = 1'b1;
            end else begin
                dout_d  = mem_q[top_idx];
                wr_en   = 1'b1;
                wr_addr = top_idx;
            end
        end else if (bus.push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_addr = count_q[AW-1:0];
                count_d = count_q + CNT_W'(1);
            end
        end else if (bus.pop) begin
            if (empty) begin
                udf_d = 1'b1;
            end else begin
                dout_d  = mem_q[top_idx];
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately not reset; only the occupancy defines valid entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= push_word;
        end
    end

`ifdef COMB_STACK_WATERMARK_EN
    logic [CNT_W-1:0] max_depth_q, max_depth_d;

    always_comb begin
        max_depth_d = max_depth_q;
        if (bus.clr) begin
            max_depth_d = '0;
        end else if (count_d > max_depth_q) begin
            max_depth_d = count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_depth_q <= '0;
        end else begin
            max_depth_q <= max_depth_d;
        end
    end

    assign bus.max_depth = max_depth_q;
`else
    assign bus.max_depth = '0;
`endif

    assign bus.dout     = dout_q;
    assign bus.count    = count_q;
    assign bus.is_empty = empty;
    assign bus.is_full  = full;
    assign bus.ovf      = ovf_q;
    assign bus.udf      = udf_q;
endmodule

// File: tb/tb_comb_stack.sv
// Directed bench for comb_stack: reset, LIFO order, replace-top, empty/full boundaries, clear.
module tb_comb_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

    typedef struct {
        logic             cl;
        logic             pu;
        logic             po;
        logic [1:0]       sel;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
        logic [WIDTH-1:0] e_dout;
        int               e_cnt;
        logic             e_ovf;
        logic             e_udf;
        int               e_max;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [WIDTH-1:0] exp_q[$];
    vec_t vec[$];

    comb_stack_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    comb_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int exp_md(input int v);
`ifdef COMB_STACK_WATERMARK_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic vec_t mk(input logic cl, input logic pu, input logic po, input logic [1:0] sel,
                                input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                                input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] e_dout,
                                input int e_cnt, input logic e_ovf, input logic e_udf, input int e_max);
        vec_t v;
        v.cl = cl; v.pu = pu; v.po = po; v.sel = sel;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.e_dout = e_dout; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_udf = e_udf; v.e_max = e_max;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [WIDTH-1:0] e_dout, input int e_cnt,
                           input logic e_ovf, input logic e_udf, input int e_max);
        chk({tag, " dout"}, 32'(bus.dout), 32'(e_dout));
        chk({tag, " count"}, 32'(bus.count), 32'(e_cnt));
        chk({tag, " is_empty"}, 32'(bus.is_empty), 32'(e_cnt == 0));
        chk({tag, " is_full"}, 32'(bus.is_full), 32'(e_cnt == DEPTH));
        chk({tag, " ovf"}, 32'(bus.ovf), 32'(e_ovf));
        chk({tag, " udf"}, 32'(bus.udf), 32'(e_udf));
        chk({tag, " max_depth"}, 32'(bus.max_depth), 32'(exp_md(e_max)));
    endtask

    task automatic cyc(input logic cl, input logic pu, input logic po, input logic [1:0] sel,
                       input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2);
        bus.clr = cl; bus.push = pu; bus.pop = po; bus.sel_stack = sel;
        bus.d0 = d0; bus.d1 = d1; bus.d2 = d2;
        @(posedge clk);
        #1;
        bus.clr = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] last_w;
        bus.clr = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.sel_stack = 2'd0;
        bus.d0 = '0; bus.d1 = '0; bus.d2 = '0;

        // Power-on reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of a stream
        cyc(0, 1, 0, 2'd0, 8'hA1, 8'h00, 8'h00);
        cyc(0, 1, 0, 2'd0, 8'hA2, 8'h00, 8'h00);
        cyc(0, 1, 0, 2'd0, 8'hA3, 8'h00, 8'h00);
        cyc(0, 0, 1, 2'd0, 8'h00, 8'h00, 8'h00);
        chk_all("pre_rst", 8'hA3, 2, 1'b0, 1'b0, 3);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 8'h00, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 1, 0, 2'd0, 8'h5A, 8'h00, 8'h00);
        cyc(0, 0, 1, 2'd0, 8'h00, 8'h00, 8'h00);
        chk_all("post_rst", 8'h5A, 0, 1'b0, 1'b0, 1);

        // Table: clr, LIFO order, empty pop, zero push, replace-top, empty push+pop, clear+watermark
        vec.push_back(mk(1, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 0, 2'd0, 8'h04, 8'h02, 8'h03, 8'h00, 1, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 2'd2, 8'h04, 8'h02, 8'h03, 8'h00, 2, 0, 0, 2));
        vec.push_back(mk(0, 1, 0, 2'd1, 8'h04, 8'h02, 8'h03, 8'h00, 3, 0, 0, 3));
        vec.push_back(mk(0, 1, 0, 2'd2, 8'h04, 8'h02, 8'h03, 8'h00, 4, 0, 0, 4));
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h04, 8'h02, 8'h03, 8'h03, 3, 0, 0, 4));
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h04, 8'h02, 8'h03, 8'h02, 2, 0, 0, 4));
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h04, 8'h02, 8'h03, 8'h03, 1, 0, 0, 4));
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h04, 8'h02, 8'h03, 8'h04, 0, 0, 0, 4));
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h04, 8'h02, 8'h03, 8'h04, 0, 0, 1, 4));
        vec.push_back(mk(0, 1, 0, 2'd3, 8'h77, 8'h66, 8'h55, 8'h04, 1, 0, 1, 4));
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 4));
        vec.push_back(mk(0, 1, 0, 2'd0, 8'h11, 8'h00, 8'h00, 8'h00, 1, 0, 1, 4));
        vec.push_back(mk(0, 1, 0, 2'd0, 8'h22, 8'h00, 8'h00, 8'h00, 2, 0, 1, 4));
        vec.push_back(mk(0, 1, 1, 2'd1, 8'h99, 8'h33, 8'h88, 8'h22, 2, 0, 1, 4));
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h33, 1, 0, 1, 4));
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h11, 0, 0, 1, 4));
        vec.push_back(mk(0, 1, 1, 2'd2, 8'h00, 8'h00, 8'h44, 8'h11, 1, 0, 1, 4));
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h44, 0, 0, 1, 4));
        vec.push_back(mk(1, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++) begin
            vec.push_back(mk(0, 1, 0, 2'd0, 8'(k), 8'h00, 8'h00, 8'h00, k, 0, 0, k));
        end
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h05, 4, 0, 0, 5));
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h04, 3, 0, 0, 5));
        vec.push_back(mk(1, 1, 0, 2'd0, 8'hAA, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));
        vec.push_back(mk(0, 0, 1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0));
        vec.push_back(mk(1, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0));

        for (int i = 0; i < vec.size(); i++) begin
            cyc(vec[i].cl, vec[i].pu, vec[i].po, vec[i].sel, vec[i].d0, vec[i].d1, vec[i].d2);
            chk_all($sformatf("v%0d", i), vec[i].e_dout, vec[i].e_cnt, vec[i].e_ovf, vec[i].e_udf, vec[i].e_max);
        end

        // Full boundary: fill, overflow push, pop must return the last accepted word
        exp_q.delete();
        for (int k = 0; k < DEPTH; k++) begin
            w = 8'($urandom_range(0, 254));
            exp_q.push_back(w);
            cyc(0, 1, 0, 2'd0, w, 8'h00, 8'h00);
        end
        chk_all("fill", 8'h00, DEPTH, 1'b0, 1'b0, DEPTH);
        cyc(0, 1, 0, 2'd0, 8'hFF, 8'h00, 8'h00);
        chk_all("ovf_push", 8'h00, DEPTH, 1'b1, 1'b0, DEPTH);
        cyc(0, 1, 1, 2'd2, 8'h00, 8'h00, 8'hC3);
        last_w = exp_q.pop_back();
        exp_q.push_back(8'hC3);
        chk_all("full_replace", last_w, DEPTH, 1'b1, 1'b0, DEPTH);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 2'd0, 8'h00, 8'h00, 8'h00);
            last_w = exp_q.pop_back();
            chk_all($sformatf("drain%0d", k), last_w, DEPTH - 1 - k, 1'b1, 1'b0, DEPTH);
        end
        cyc(1, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00);
        chk_all("final_clr", 8'h00, 0, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
